// File: rtl/l1_mem_arbiter_pkg.sv
// Shared definitions for the L1 <-> MMU line arbiter: FSM encodings,
// default widths and grant-owner constants.
package l1_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/l1_mem_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave (MMU) line arbiter with
// D priority and a saturating starvation counter that forces I through.
//
// state        | meaning
// ARB_IDLE     | no transaction; pick a master, latch its request
// ARB_GRANT_I  | I-cache transaction in flight, waiting for mmu_done
// ARB_GRANT_D  | D-cache transaction in flight, waiting for mmu_done
// ARB_RELEASE  | one-cycle gap so the finished master can drop its request
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int LINE_W       = DEF_LINE_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              ic_req_read,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_req_read,
    input  logic              dc_req_write,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_read_data,
    output logic              mmu_req_read,
    output logic              mmu_req_write,
    output logic [ADDR_W-1:0] mmu_req_addr,
    output logic [LINE_W-1:0] mmu_write_data,
    input  logic              mmu_done,
    input  logic [LINE_W-1:0] mmu_read_data,
    output logic              arb_busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_i;
    logic             grant_d;
    logic             grant_owner;
    logic             dc_req_any;
    logic             starve_hit;
    logic             xfer_done;

    assign dc_req_any = dc_req_read | dc_req_write;
    assign starve_hit = (starve_cnt == CNT_LIMIT);
    assign xfer_done  = mmu_done &&
                        ((state_q == ARB_GRANT_I) || (state_q == ARB_GRANT_D));

    always_comb begin
        state_d     = state_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        grant_owner = OWNER_I;
        case (state_q)
            ARB_IDLE: begin
                if (dc_req_any && !(ic_req_read && starve_hit)) begin
                    grant_d     = 1'b1;
                    grant_owner = OWNER_D;
                    state_d     = ARB_GRANT_D;
                end else if (ic_req_read) begin
                    grant_i     = 1'b1;
                    grant_owner = OWNER_I;
                    state_d     = ARB_GRANT_I;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                if (mmu_done) state_d = ARB_RELEASE;
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            starve_cnt     <= '0;
            mmu_req_read   <= 1'b0;
            mmu_req_write  <= 1'b0;
            mmu_req_addr   <= '0;
            mmu_write_data <= '0;
        end else begin
            state_q <= state_d;

            if (grant_i || grant_d) begin
                if (grant_owner == OWNER_D) begin
                    // a write-back wins over a fill when both are raised
                    mmu_req_write  <= dc_req_write;
                    mmu_req_read   <= ~dc_req_write;
                    mmu_req_addr   <= dc_req_addr;
                    mmu_write_data <= dc_write_data;
                end else begin
                    mmu_req_write  <= 1'b0;
                    mmu_req_read   <= 1'b1;
                    mmu_req_addr   <= ic_req_addr;
                    mmu_write_data <= '0;
                end
            end else if (xfer_done) begin
                mmu_req_read  <= 1'b0;
                mmu_req_write <= 1'b0;
            end

            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && ic_req_read) begin
                if (!starve_hit) starve_cnt <= starve_cnt + CNT_W'(1);
            end else if ((state_q == ARB_IDLE) && !ic_req_read) begin
                starve_cnt <= '0;
            end
        end
    end

    // reset aborts an in-flight transaction without a completion pulse
    assign ic_done      = rst_n && mmu_done && (state_q == ARB_GRANT_I);
    assign dc_done      = rst_n && mmu_done && (state_q == ARB_GRANT_D);
    assign ic_read_data = mmu_read_data;
    assign dc_read_data = mmu_read_data;
    assign arb_busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed per scenario.
module tb_l1_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic          ic_req_read;
    logic [AW-1:0] ic_req_addr;
    logic          ic_done;
    logic [LW-1:0] ic_read_data;
    logic          dc_req_read;
    logic          dc_req_write;
    logic [AW-1:0] dc_req_addr;
    logic [LW-1:0] dc_write_data;
    logic          dc_done;
    logic [LW-1:0] dc_read_data;
    logic          mmu_req_read;
    logic          mmu_req_write;
    logic [AW-1:0] mmu_req_addr;
    logic [LW-1:0] mmu_write_data;
    logic          mmu_done;
    logic [LW-1:0] mmu_read_data;
    logic          arb_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(4)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .ic_req_read(ic_req_read), .ic_req_addr(ic_req_addr),
        .ic_done(ic_done), .ic_read_data(ic_read_data),
        .dc_req_read(dc_req_read), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_write_data(dc_write_data),
        .dc_done(dc_done), .dc_read_data(dc_read_data),
        .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write),
        .mmu_req_addr(mmu_req_addr), .mmu_write_data(mmu_write_data),
        .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
        .arb_busy(arb_busy)
    );

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (mmu_req_read || mmu_req_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        vec_cnt++;
        if ({mmu_req_read, mmu_req_write, arb_busy, ic_done, dc_done} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {mmu_req_read, mmu_req_write, arb_busy, ic_done, dc_done});
        end
        vec_cnt++;
        if (mmu_req_addr !== 32'h0 || mmu_write_data !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: got addr %h data %h expected 0", mmu_req_addr, mmu_write_data);
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_i_only();
        logic [LW-1:0] pat;
        pat = {8{32'hC0DE_0040}};
        ic_req_read = 1'b1;
        ic_req_addr = 32'h0000_0040;
        @(negedge sys_clk);
        vec_cnt++;
        if ({mmu_req_read, mmu_req_write, arb_busy} !== 3'b101 || mmu_req_addr !== 32'h40) begin
            err_cnt++;
            $display("FAIL i_grant: got rd/wr/busy %b addr %h expected 101 addr 00000040",
                     {mmu_req_read, mmu_req_write, arb_busy}, mmu_req_addr);
        end
        vec_cnt++;
        if (mmu_write_data !== '0) begin
            err_cnt++;
            $display("FAIL i_wdata: got %h expected 0", mmu_write_data);
        end
        repeat (3) @(negedge sys_clk);
        vec_cnt++;
        if (mmu_req_read !== 1'b1 || mmu_req_addr !== 32'h40 || ic_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL i_hold: got rd %b addr %h done %b expected 1 00000040 0",
                     mmu_req_read, mmu_req_addr, ic_done);
        end
        mmu_done = 1'b1;
        mmu_read_data = pat;
        #1;
        vec_cnt++;
        if (ic_done !== 1'b1 || dc_done !== 1'b0 || ic_read_data !== pat) begin
            err_cnt++;
            $display("FAIL i_done: got ic %b dc %b data %h expected 1 0 %h",
                     ic_done, dc_done, ic_read_data, pat);
        end
        @(negedge sys_clk);
        mmu_done = 1'b0;
        ic_req_read = 1'b0;
        #1;
        vec_cnt++;
        if ({arb_busy, mmu_req_read, ic_done} !== 3'b100) begin
            err_cnt++;
            $display("FAIL i_release: got busy/rd/done %b expected 100", {arb_busy, mmu_req_read, ic_done});
        end
        @(negedge sys_clk);
        vec_cnt++;
        if (arb_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL i_idle: got busy %b expected 0", arb_busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [LW-1:0] wd;
        logic [LW-1:0] pat;
        bit ok;
        wd  = {8{32'h5A5A_0200}};
        pat = {8{32'h1234_0100}};
        ic_req_read   = 1'b1;
        ic_req_addr   = 32'h100;
        dc_req_write  = 1'b1;
        dc_req_addr   = 32'h200;
        dc_write_data = wd;
        @(negedge sys_clk);
        vec_cnt++;
        if ({mmu_req_read, mmu_req_write} !== 2'b01 || mmu_req_addr !== 32'h200 || mmu_write_data !== wd) begin
            err_cnt++;
            $display("FAIL sim_d_first: got rd/wr %b addr %h expected 01 addr 00000200 data match",
                     {mmu_req_read, mmu_req_write}, mmu_req_addr);
        end
        @(negedge sys_clk);
        mmu_done = 1'b1;
        #1;
        vec_cnt++;
        if ({dc_done, ic_done} !== 2'b10) begin
            err_cnt++;
            $display("FAIL sim_d_done: got dc/ic %b expected 10", {dc_done, ic_done});
        end
        @(negedge sys_clk);
        mmu_done = 1'b0;
        dc_req_write = 1'b0;
        @(negedge sys_clk);
        vec_cnt++;
        if ({arb_busy, mmu_req_read, mmu_req_write} !== 3'b000) begin
            err_cnt++;
            $display("FAIL sim_gap: got busy/rd/wr %b expected 000", {arb_busy, mmu_req_read, mmu_req_write});
        end
        wait_req(ok);
        vec_cnt++;
        if (!ok || {mmu_req_read, mmu_req_write} !== 2'b10 || mmu_req_addr !== 32'h100 || mmu_write_data !== '0) begin
            err_cnt++;
            $display("FAIL sim_i_second: got ok %0d rd/wr %b addr %h expected 1 10 addr 00000100",
                     ok, {mmu_req_read, mmu_req_write}, mmu_req_addr);
        end
        mmu_done = 1'b1;
        mmu_read_data = pat;
        #1;
        vec_cnt++;
        if (ic_done !== 1'b1 || dc_done !== 1'b0 || ic_read_data !== pat) begin
            err_cnt++;
            $display("FAIL sim_i_done: got ic %b dc %b expected 1 0", ic_done, dc_done);
        end
        @(negedge sys_clk);
        mmu_done = 1'b0;
        ic_req_read = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_starvation();
        // D held continuously, I held: D x4, then I, then D again (counter cleared)
        logic exp_owner [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [AW-1:0] exp_addr;
        bit ok;
        ic_req_read = 1'b1;
        ic_req_addr = 32'h500;
        dc_req_read = 1'b1;
        dc_req_addr = 32'hA00;
        for (int g = 0; g < 6; g++) begin
            wait_req(ok);
            exp_addr = exp_owner[g] ? 32'hA00 : 32'h500;
            vec_cnt++;
            if (!ok || mmu_req_read !== 1'b1 || mmu_req_addr !== exp_addr) begin
                err_cnt++;
                $display("FAIL starve_grant%0d: got ok %0d rd %b addr %h expected 1 1 addr %h",
                         g, ok, mmu_req_read, mmu_req_addr, exp_addr);
            end
            mmu_done = 1'b1;
            #1;
            vec_cnt++;
            if ({dc_done, ic_done} !== {exp_owner[g], ~exp_owner[g]}) begin
                err_cnt++;
                $display("FAIL starve_done%0d: got dc/ic %b expected %b",
                         g, {dc_done, ic_done}, {exp_owner[g], ~exp_owner[g]});
            end
            @(negedge sys_clk);
            mmu_done = 1'b0;
            if (g == 5) begin
                dc_req_read = 1'b0;
                ic_req_read = 1'b0;
            end
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_rw_priority();
        dc_req_read   = 1'b1;
        dc_req_write  = 1'b1;
        dc_req_addr   = 32'h300;
        dc_write_data = {8{32'hFEED_0300}};
        @(negedge sys_clk);
        vec_cnt++;
        if ({mmu_req_read, mmu_req_write} !== 2'b01 || mmu_req_addr !== 32'h300) begin
            err_cnt++;
            $display("FAIL rw_prio: got rd/wr %b addr %h expected 01 addr 00000300",
                     {mmu_req_read, mmu_req_write}, mmu_req_addr);
        end
        mmu_done = 1'b1;
        @(negedge sys_clk);
        mmu_done = 1'b0;
        dc_req_read = 1'b0;
        dc_req_write = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_done_in_idle();
        mmu_done = 1'b1;
        #1;
        vec_cnt++;
        if ({ic_done, dc_done} !== 2'b00) begin
            err_cnt++;
            $display("FAIL idle_done: got ic/dc %b expected 00", {ic_done, dc_done});
        end
        @(negedge sys_clk);
        mmu_done = 1'b0;
        vec_cnt++;
        if ({arb_busy, mmu_req_read, mmu_req_write} !== 3'b000) begin
            err_cnt++;
            $display("FAIL idle_stay: got busy/rd/wr %b expected 000", {arb_busy, mmu_req_read, mmu_req_write});
        end
    endtask

    task automatic test_drop_in_grant();
        dc_req_write  = 1'b1;
        dc_req_addr   = 32'h900;
        dc_write_data = {8{32'hBEEF_0900}};
        @(negedge sys_clk);
        dc_req_write  = 1'b0;
        dc_req_addr   = 32'h0;
        dc_write_data = '0;
        @(negedge sys_clk);
        vec_cnt++;
        if (mmu_req_write !== 1'b1 || mmu_req_addr !== 32'h900 || mmu_write_data !== {8{32'hBEEF_0900}}) begin
            err_cnt++;
            $display("FAIL drop_hold: got wr %b addr %h expected 1 addr 00000900", mmu_req_write, mmu_req_addr);
        end
        mmu_done = 1'b1;
        #1;
        vec_cnt++;
        if (dc_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL drop_done: got %b expected 1", dc_done);
        end
        @(negedge sys_clk);
        mmu_done = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        dc_req_read = 1'b1;
        dc_req_addr = 32'h700;
        @(negedge sys_clk);
        vec_cnt++;
        if (arb_busy !== 1'b1 || mmu_req_read !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_pre: got busy %b rd %b expected 1 1", arb_busy, mmu_req_read);
        end
        rst_n = 1'b0;
        dc_req_read = 1'b0;
        #1;
        vec_cnt++;
        if (dc_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_nodone: got %b expected 0", dc_done);
        end
        @(negedge sys_clk);
        vec_cnt++;
        if ({mmu_req_read, mmu_req_write, arb_busy, dc_done} !== 4'b0000 || mmu_req_addr !== 32'h0) begin
            err_cnt++;
            $display("FAIL rst_mid: got rd/wr/busy/done %b addr %h expected 0000 addr 0",
                     {mmu_req_read, mmu_req_write, arb_busy, dc_done}, mmu_req_addr);
        end
        rst_n = 1'b1;
        ic_req_read = 1'b1;
        ic_req_addr = 32'h800;
        wait_req(ok);
        vec_cnt++;
        if (!ok || mmu_req_read !== 1'b1 || mmu_req_addr !== 32'h800) begin
            err_cnt++;
            $display("FAIL rst_after: got ok %0d rd %b addr %h expected 1 1 addr 00000800",
                     ok, mmu_req_read, mmu_req_addr);
        end
        mmu_done = 1'b1;
        mmu_read_data = {8{32'h0800_0800}};
        #1;
        vec_cnt++;
        if (ic_done !== 1'b1 || ic_read_data !== {8{32'h0800_0800}}) begin
            err_cnt++;
            $display("FAIL rst_after_done: got %b expected 1", ic_done);
        end
        @(negedge sys_clk);
        mmu_done = 1'b0;
        ic_req_read = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        ic_req_read   = 1'b0;
        ic_req_addr   = '0;
        dc_req_read   = 1'b0;
        dc_req_write  = 1'b0;
        dc_req_addr   = '0;
        dc_write_data = '0;
        mmu_done      = 1'b0;
        mmu_read_data = '0;
        rst_n         = 1'b0;
        test_reset();
        test_i_only();
        test_simultaneous();
        test_starvation();
        test_rw_priority();
        test_done_in_idle();
        test_drop_in_grant();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
Two-master, one-slave arbiter between the L1 caches and the memory MMU.
- Masters: L1 instruction cache (read-only line fills) and L1 data cache (line fills and write-backs).
- Slave: the shared l1mmu port.
- Serializes one 256-bit line transaction at a time, latches request fields, and routes done/read data back to the granted master.
- Data cache has priority; a bounded anti-starvation counter guarantees instruction-fetch progress.

Parameters:
ADDR_W, 32, request address width
LINE_W, 256, cache line / transfer width
STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting before I is forced

Ports:
sys_clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ic_req_read  in  1  I-cache line read request (level, held until ic_done)
ic_req_addr  in  ADDR_W  I-cache line address
ic_done  out  1  one-cycle completion pulse to I-cache
ic_read_data  out  LINE_W  line data to I-cache, valid with ic_done
dc_req_read  in  1  D-cache line read request (level)
dc_req_write  in  1  D-cache line write request (level)
dc_req_addr  in  ADDR_W  D-cache line address
dc_write_data  in  LINE_W  D-cache write line
dc_done  out  1  one-cycle completion pulse to D-cache
dc_read_data  out  LINE_W  line data to D-cache, valid with dc_done
mmu_req_read  out  1  registered read request to MMU
mmu_req_write  out  1  registered write request to MMU
mmu_req_addr  out  ADDR_W  registered address to MMU
mmu_write_data  out  LINE_W  registered write line to MMU
mmu_done  in  1  one-cycle completion pulse from MMU
mmu_read_data  in  LINE_W  MMU read line, valid with mmu_done
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: sys_clk, rst_n synchronous active-low.
  - State goes to IDLE; starvation counter goes to 0.
  - mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data, arb_busy all go to 0.
  - Reset asserted mid-transaction aborts it with no done pulse. The MMU shares rst_n and resets in the same cycle.
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE, choosing a master:
  - Only D requesting: grant D.
  - Only I requesting: grant I.
  - Both requesting: grant D, unless the counter equals STARVE_LIMIT, then grant I.
  - On grant, latch addr/data/type into the mmu_* registers and move to GRANT_x.
  - Latency: request seen in IDLE at cycle N → mmu_req_* high at cycle N+1.
- D request type:
  - dc_req_write wins if both read and write are high; mmu_req_read is forced to 0.
  - I grants always drive mmu_req_write=0 and mmu_write_data=0.
- GRANT_x:
  - mmu_req_* are held constant until mmu_done.
  - In the mmu_done cycle, x_done = 1 combinationally and x_read_data = mmu_read_data; the other master's done stays 0.
  - Next state is RELEASE, with mmu_req_read/write cleared.
- RELEASE: exactly one cycle, giving the master time to drop its request; then IDLE. Minimum back-to-back spacing is 2 idle cycles on the MMU request lines.
- Starvation counter (width clog2(STARVE_LIMIT+1), saturating):
  - +1 on each D grant made while ic_req_read=1.
  - Cleared on any I grant.
  - Cleared in IDLE when ic_req_read=0.
- Boundary conditions:
  - mmu_done in IDLE/RELEASE: ignored, no done forwarded.
  - Master drops its request during GRANT (protocol violation): the transaction still completes on the latched values and done is still pulsed.
  - A request arriving in RELEASE is not accepted until IDLE.
- Data paths:
  - ic_read_data and dc_read_data are direct fan-outs of mmu_read_data; only the done pulses qualify them.

Decomposition:
- Shared package: FSM state encodings (ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D, ARB_RELEASE), LINE_W/ADDR_W defaults, and owner encoding constants.
- Single module. The FSM and counter are small enough that no sub-module is warranted.

Test Plan:
- I-only read, addr 0x0000_0040, MMU done after 5 cycles → mmu_req_read=1 from cycle N+1; ic_done a single pulse carrying the 256-bit pattern; dc_done stays 0; 1 RELEASE cycle, then IDLE.
- Simultaneous I read 0x100 and D write 0x200 → D granted first (mmu_req_write=1, addr 0x200, data matches); after dc_done and RELEASE, I granted with addr 0x100.
- D requests continuously with I held high, STARVE_LIMIT=4 → exactly 4 D grants, then an I grant; counter returns to 0.
- dc_req_read=dc_req_write=1 at addr 0x300 → mmu_req_write=1 and mmu_req_read=0.
- mmu_done pulsed while IDLE → no ic_done/dc_done; state stays IDLE.
- rst_n=0 during GRANT_D → next cycle all mmu_req_* = 0, arb_busy=0, no done pulse; a new I request after reset is served normally.
